// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths, vector addresses and fetch-state encoding.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] RESET_VEC_ADDR = 8'h00;
  localparam logic [DATA_W-1:0] INT_VEC_ADDR   = 8'h01;

  typedef enum logic [1:0] {
    S_RSTVEC = 2'd0,
    S_RUN    = 2'd1,
    S_INTVEC = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : IF/ID pipeline register with hold enable and valid-only flush.
// Revision : 1.0
// ============================================================================
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int W = cpu_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         flush_i,
  input  logic [W-1:0] instr_i,
  input  logic [W-1:0] pc_plus1_i,
  output logic [W-1:0] instr_o,
  output logic [W-1:0] pc_plus1_o,
  output logic         valid_o
);

  logic [W-1:0] instr_q,    instr_d;
  logic [W-1:0] pc_plus1_q, pc_plus1_d;
  logic         valid_q,    valid_d;

  // Flush only drops valid; the payload keeps its last value.
  always_comb begin
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (en_i) begin
      instr_d    = instr_i;
      pc_plus1_d = pc_plus1_i;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus1_o = pc_plus1_q;
  assign valid_o    = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage: PC, vector loads, redirect, IF/ID reg.
// Revision : 1.0
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                 DATA_W         = cpu_pkg::DATA_W,
  parameter logic [DATA_W-1:0]  RESET_VEC_ADDR = cpu_pkg::RESET_VEC_ADDR,
  parameter logic [DATA_W-1:0]  INT_VEC_ADDR   = cpu_pkg::INT_VEC_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              intr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] imem_addr,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_pc_plus1,
  output logic              if_id_valid,
  output logic              int_ack,
  output logic [DATA_W-1:0] int_ret_pc
);

  fetch_state_e      state_q,       state_d;
  logic [DATA_W-1:0] pc_q,          pc_d;
  logic              int_pending_q, int_pending_d;
  logic              int_ack_q,     int_ack_d;
  logic [DATA_W-1:0] int_ret_pc_q,  int_ret_pc_d;

  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] pc_plus1;
  logic              ifid_flush;

  assign pc_plus1 = pc_q + {{(DATA_W-1){1'b0}}, 1'b1};

  // A new request wins over the clear that happens when leaving S_INTVEC.
  assign int_pending_d = intr | (int_pending_q & (state_q != S_INTVEC));

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    int_ack_d    = int_ack_q;
    int_ret_pc_d = int_ret_pc_q;
    ifid_flush   = 1'b0;
    addr         = pc_q;
    case (state_q)
      S_RSTVEC: begin
        addr       = RESET_VEC_ADDR;
        pc_d       = imem_data;
        ifid_flush = 1'b1;
        state_d    = S_RUN;
      end
      S_INTVEC: begin
        addr       = INT_VEC_ADDR;
        pc_d       = imem_data;
        ifid_flush = 1'b1;
        int_ack_d  = 1'b0;
        state_d    = S_RUN;
      end
      S_RUN: begin
        if (branch_taken) begin
          pc_d       = branch_target;
          ifid_flush = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (int_pending_q) begin
          // PC is not advanced so the un-issued byte is refetched on return.
          ifid_flush   = 1'b1;
          int_ret_pc_d = pc_q;
          int_ack_d    = 1'b1;
          state_d      = S_INTVEC;
        end else begin
          pc_d = pc_plus1;
        end
      end
      default: begin
        addr    = RESET_VEC_ADDR;
        state_d = S_RSTVEC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RSTVEC;
      pc_q          <= '0;
      int_pending_q <= 1'b0;
      int_ack_q     <= 1'b0;
      int_ret_pc_q  <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      int_pending_q <= int_pending_d;
      int_ack_q     <= int_ack_d;
      int_ret_pc_q  <= int_ret_pc_d;
    end
  end

  if_id_reg #(
    .W (DATA_W)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .en_i       (~stall),
    .flush_i    (ifid_flush),
    .instr_i    (imem_data),
    .pc_plus1_i (pc_plus1),
    .instr_o    (if_id_instr),
    .pc_plus1_o (if_id_pc_plus1),
    .valid_o    (if_id_valid)
  );

  assign imem_addr  = addr;
  assign int_ack    = int_ack_q;
  assign int_ret_pc = int_ret_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed scoreboard bench for fetch_unit.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] branch_target = 8'h00;
  logic       intr = 1'b0;
  logic [7:0] imem_data;
  logic [7:0] imem_addr;
  logic [7:0] if_id_instr;
  logic [7:0] if_id_pc_plus1;
  logic       if_id_valid;
  logic       int_ack;
  logic [7:0] int_ret_pc;

  logic [7:0] mem [256];

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] instr;
    logic [7:0] pc1;
    logic       valid;
    logic       ack;
    logic [7:0] ret;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    tests = 0;
  int    fails = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .intr           (intr),
    .imem_data      (imem_data),
    .imem_addr      (imem_addr),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .int_ack        (int_ack),
    .int_ret_pc     (int_ret_pc)
  );

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  function automatic exp_t E(input logic [7:0] a, input logic [7:0] i,
                             input logic [7:0] p, input logic v,
                             input logic k, input logic [7:0] r);
    exp_t e;
    e.addr = a; e.instr = i; e.pc1 = p; e.valid = v; e.ack = k; e.ret = r;
    return e;
  endfunction

  task automatic chk(input string tag, input string field,
                     input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
    end
  endtask

  task automatic compare();
    exp_t  e;
    string t;
    e = sb.pop_front();
    t = tags.pop_front();
    chk(t, "imem_addr",  imem_addr,              e.addr);
    chk(t, "instr",      if_id_instr,            e.instr);
    chk(t, "pc_plus1",   if_id_pc_plus1,         e.pc1);
    chk(t, "valid",      {7'd0, if_id_valid},    {7'd0, e.valid});
    chk(t, "int_ack",    {7'd0, int_ack},        {7'd0, e.ack});
    chk(t, "int_ret_pc", int_ret_pc,             e.ret);
  endtask

  task automatic now_check(input exp_t e, input string tag);
    sb.push_back(e);
    tags.push_back(tag);
    compare();
  endtask

  task automatic step(input logic s, input logic b, input logic [7:0] t,
                      input logic i, input exp_t e, input string tag);
    stall = s; branch_taken = b; branch_target = t; intr = i;
    sb.push_back(e);
    tags.push_back(tag);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h5A;
    mem[8'h00] = 8'h10;
    mem[8'h01] = 8'h80;
    mem[8'h10] = 8'hA1;
    mem[8'h11] = 8'hA2;
    mem[8'h12] = 8'hA3;
    mem[8'hFF] = 8'h55;

    #2;
    now_check(E(8'h00, 8'h00, 8'h00, 0, 0, 8'h00), "reset");
    #10 rst = 1'b0;
    now_check(E(8'h00, 8'h00, 8'h00, 0, 0, 8'h00), "rstvec_addr");

    step(0, 0, 8'h00, 0, E(8'h10, 8'h00, 8'h00, 0, 0, 8'h00), "rstvec_load");
    step(0, 0, 8'h00, 0, E(8'h11, 8'hA1, 8'h11, 1, 0, 8'h00), "fetch_a1");
    step(0, 0, 8'h00, 0, E(8'h12, 8'hA2, 8'h12, 1, 0, 8'h00), "fetch_a2");
    for (int k = 0; k < 3; k++)
      step(1, 0, 8'h00, 0, E(8'h12, 8'hA2, 8'h12, 1, 0, 8'h00), "stall_hold");
    step(0, 0, 8'h00, 0, E(8'h13, 8'hA3, 8'h13, 1, 0, 8'h00), "fetch_a3");
    step(1, 1, 8'h40, 0, E(8'h40, 8'hA3, 8'h13, 0, 0, 8'h00), "branch_over_stall");
    step(0, 0, 8'h00, 0, E(8'h41, 8'h1A, 8'h41, 1, 0, 8'h00), "resume_40");

    step(0, 1, 8'hFE, 0, E(8'hFE, 8'h1A, 8'h41, 0, 0, 8'h00), "branch_fe");
    step(0, 0, 8'h00, 0, E(8'hFF, 8'hA4, 8'hFF, 1, 0, 8'h00), "fetch_fe");
    step(0, 0, 8'h00, 0, E(8'h00, 8'h55, 8'h00, 1, 0, 8'h00), "wrap_ff");
    step(0, 0, 8'h00, 0, E(8'h01, 8'h10, 8'h01, 1, 0, 8'h00), "after_wrap");

    step(0, 1, 8'h21, 0, E(8'h21, 8'h10, 8'h01, 0, 0, 8'h00), "branch_21");
    step(0, 0, 8'h00, 1, E(8'h22, 8'h7B, 8'h22, 1, 0, 8'h00), "intr_pulse");
    step(0, 0, 8'h00, 0, E(8'h01, 8'h7B, 8'h22, 0, 1, 8'h22), "int_ack");
    step(0, 0, 8'h00, 0, E(8'h80, 8'h7B, 8'h22, 0, 0, 8'h22), "isr_load");
    step(0, 0, 8'h00, 0, E(8'h81, 8'hDA, 8'h81, 1, 0, 8'h22), "isr_fetch");

    step(0, 1, 8'h30, 1, E(8'h30, 8'hDA, 8'h81, 0, 0, 8'h22), "collide_branch");
    step(0, 0, 8'h00, 0, E(8'h01, 8'hDA, 8'h81, 0, 1, 8'h30), "collide_ack");
    step(0, 0, 8'h00, 0, E(8'h80, 8'hDA, 8'h81, 0, 0, 8'h30), "collide_isr");
    step(0, 0, 8'h00, 0, E(8'h81, 8'hDA, 8'h81, 1, 0, 8'h30), "collide_fetch");

    step(0, 0, 8'h00, 1, E(8'h82, 8'hDB, 8'h82, 1, 0, 8'h30), "intr2");
    step(0, 0, 8'h00, 0, E(8'h01, 8'hDB, 8'h82, 0, 1, 8'h82), "intr2_ack");
    #2 rst = 1'b1;
    #1;
    now_check(E(8'h00, 8'h00, 8'h00, 0, 0, 8'h00), "async_reset");
    #3 rst = 1'b0;
    step(0, 0, 8'h00, 0, E(8'h10, 8'h00, 8'h00, 0, 0, 8'h00), "rerun_rstvec");
    step(0, 0, 8'h00, 0, E(8'h11, 8'hA1, 8'h11, 1, 0, 8'h00), "rerun_a1");
    step(0, 0, 8'h00, 0, E(8'h12, 8'hA2, 8'h12, 1, 0, 8'h00), "rerun_no_int");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
